// File: rtl/lcd_cmd_host_if.sv
// Bus bundle between the LCD command host and its environment: command ROM port,
// LCD_CTRL command handshake, and the shared IRAM / expected-image readback port.
interface lcd_cmd_host_if;
  logic       cmd_rom_rd;
  logic [5:0] cmd_rom_a;
  logic [3:0] cmd_rom_q;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       rb_rd;
  logic [5:0] rb_a;
  logic [7:0] ram_q;
  logic [7:0] exp_q;

  modport master (
    output cmd_rom_rd, cmd_rom_a, cmd, cmd_valid, rb_rd, rb_a,
    input  cmd_rom_q, busy, done, ram_q, exp_q
  );

  modport slave (
    input  cmd_rom_rd, cmd_rom_a, cmd, cmd_valid, rb_rd, rb_a,
    output cmd_rom_q, busy, done, ram_q, exp_q
  );
endinterface

// File: rtl/lcd_cmd_host.sv
// Host-side initiator for LCD_CTRL: streams a command list from ROM under the busy
// handshake, waits for the write to complete, then checks IRAM against an expected image.
module lcd_cmd_host #(
  parameter int N_CMD   = 46,
  parameter int N_PIX   = 64,
  parameter int TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  lcd_cmd_host_if.master        bus,
  output logic [6:0]            cmds_sent,
  output logic [6:0]            err_cnt,
  output logic                  finish,
  output logic                  pass,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_Q,
    S_ISSUE,
    S_HOLD,
    S_WAIT_DONE,
    S_RB,
    S_FINISH
  } state_t;

  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CYC_LIM = CW'(TIMEOUT);
  localparam logic [CW-1:0]   CYC_ONE = CW'(1);
  localparam logic [6:0]      CMD_LIM = 7'(N_CMD);
  localparam logic [6:0]      PIX_LIM = 7'(N_PIX);

  state_t        state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_rom_rd_q, cmd_rom_rd_d;
  logic          rb_rd_q, rb_rd_d;
  logic [6:0]    rb_cnt_q, rb_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] cyc_inc;
  logic [6:0]    cmds_sent_q, cmds_sent_d;
  logic [6:0]    err_cnt_q, err_cnt_d;
  logic          finish_q, finish_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    rb_cnt_d    = rb_cnt_q;
    cyc_d       = cyc_q;
    cmds_sent_d = cmds_sent_q;
    err_cnt_d   = err_cnt_q;
    timeout_d   = timeout_q;
    cyc_inc     = cyc_q + CYC_ONE;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d     = S_FETCH;
          idx_d       = 7'd0;
          cmds_sent_d = 7'd0;
          err_cnt_d   = 7'd0;
          timeout_d   = 1'b0;
          cyc_d       = '0;
        end
      end
      default: begin
        cyc_d = cyc_inc;
        // The cycle limit overrides whatever transition the active state wanted.
        if (cyc_inc == CYC_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          case (state_q)
            S_FETCH:  state_d = S_WAIT_Q;
            S_WAIT_Q: begin
              cmd_d   = bus.cmd_rom_q;
              state_d = S_ISSUE;
            end
            S_ISSUE: begin
              if (!bus.busy) begin
                cmds_sent_d = cmds_sent_q + 7'd1;
                idx_d       = idx_q + 7'd1;
                state_d     = S_HOLD;
              end
            end
            // cmd_q still holds the command just accepted; busy is deliberately ignored here.
            S_HOLD: begin
              if (cmd_q == 4'h0 || idx_q == CMD_LIM) state_d = S_WAIT_DONE;
              else                                   state_d = S_FETCH;
            end
            S_WAIT_DONE: begin
              if (bus.done) begin
                rb_cnt_d = 7'd0;
                state_d  = S_RB;
              end
            end
            S_RB: begin
              // Data returned this cycle belongs to the read issued one cycle earlier.
              if (rb_cnt_q != 7'd0 && bus.ram_q != bus.exp_q) err_cnt_d = err_cnt_q + 7'd1;
              if (rb_cnt_q == PIX_LIM) state_d  = S_FINISH;
              else                     rb_cnt_d = rb_cnt_q + 7'd1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    // Strobes are decoded from the next state so they leave the flops already aligned.
    cmd_rom_rd_d = (state_d == S_FETCH);
    cmd_valid_d  = (state_d == S_ISSUE);
    rb_rd_d      = (state_d == S_RB) && (rb_cnt_d < PIX_LIM);
    finish_d     = (state_d == S_FINISH);
    pass_d       = finish_d && (err_cnt_d == 7'd0) && !timeout_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 7'd0;
      cmd_q        <= 4'h0;
      cmd_valid_q  <= 1'b0;
      cmd_rom_rd_q <= 1'b0;
      rb_rd_q      <= 1'b0;
      rb_cnt_q     <= 7'd0;
      cyc_q        <= '0;
      cmds_sent_q  <= 7'd0;
      err_cnt_q    <= 7'd0;
      finish_q     <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_rom_rd_q <= cmd_rom_rd_d;
      rb_rd_q      <= rb_rd_d;
      rb_cnt_q     <= rb_cnt_d;
      cyc_q        <= cyc_d;
      cmds_sent_q  <= cmds_sent_d;
      err_cnt_q    <= err_cnt_d;
      finish_q     <= finish_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.cmd_rom_rd = cmd_rom_rd_q;
  assign bus.cmd_rom_a  = idx_q[5:0];
  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.rb_rd      = rb_rd_q;
  assign bus.rb_a       = rb_cnt_q[5:0];
  assign cmds_sent      = cmds_sent_q;
  assign err_cnt        = err_cnt_q;
  assign finish         = finish_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host: ROM / IRAM / LCD_CTRL models around the DUT,
// hand-computed expectations per scenario.
module tb_lcd_cmd_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] cmds_sent;
  logic [6:0] err_cnt;
  logic       finish;
  logic       pass;
  logic       timeout;

  lcd_cmd_host_if bus ();

  lcd_cmd_host #(.N_CMD(46), .N_PIX(64), .TIMEOUT(1000)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cmds_sent (cmds_sent),
    .err_cnt   (err_cnt),
    .finish    (finish),
    .pass      (pass),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Environment memories with registered read
  logic [3:0] cmd_rom [64];
  logic [7:0] iram    [64];
  logic [7:0] exp_rom [64];
  logic [3:0] rom_q = 4'h0;
  logic [7:0] ram_q = 8'h0;
  logic [7:0] exp_q = 8'h0;

  always @(posedge clk) begin
    if (bus.cmd_rom_rd) rom_q <= cmd_rom[bus.cmd_rom_a];
    if (bus.rb_rd) begin
      ram_q <= iram[bus.rb_a];
      exp_q <= exp_rom[bus.rb_a];
    end
  end

  assign bus.cmd_rom_q = rom_q;
  assign bus.ram_q     = ram_q;
  assign bus.exp_q     = exp_q;

  // LCD_CTRL model: busy for 2 cycles after each accept, done 6 cycles after a write
  logic force_busy;
  logic done_en;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) begin
    if (bus.cmd_valid && !bus.busy) busy_cnt <= 2;
    else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
    if (bus.cmd_valid && !bus.busy && bus.cmd == 4'h0 && done_en) done_cnt <= 6;
    else if (done_cnt != 0)                                       done_cnt <= done_cnt - 1;
  end

  assign bus.busy = force_busy | (busy_cnt != 0);
  assign bus.done = (done_cnt == 1);

  // Transaction monitor
  logic tb_clr;
  int   cyc = 0;
  int   acc_n = 0, seq_err = 0, stray = 0, rb_n = 0, rb_seq_err = 0;
  int   done_cyc = -1, rb_first = -1;
  logic wr_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_clr) begin
      acc_n      <= 0;
      seq_err    <= 0;
      stray      <= 0;
      wr_seen    <= 1'b0;
      rb_n       <= 0;
      rb_seq_err <= 0;
      done_cyc   <= -1;
      rb_first   <= -1;
    end else begin
      if (bus.cmd_valid && wr_seen) stray <= stray + 1;
      if (bus.cmd_valid && !bus.busy) begin
        if (bus.cmd !== cmd_rom[acc_n[5:0]]) seq_err <= seq_err + 1;
        acc_n <= acc_n + 1;
        if (bus.cmd == 4'h0) wr_seen <= 1'b1;
      end
      if (bus.done) done_cyc <= cyc;
      if (bus.rb_rd) begin
        if (rb_n == 0) rb_first <= cyc;
        if (int'(bus.rb_a) != rb_n) rb_seq_err <= rb_seq_err + 1;
        rb_n <= rb_n + 1;
      end
    end
  end

  task automatic load_list(input int wr_at);
    for (int i = 0; i < 64; i++) cmd_rom[i] = (i == wr_at) ? 4'h0 : 4'((i % 15) + 1);
  endtask

  task automatic load_img();
    for (int i = 0; i < 64; i++) begin
      exp_rom[i] = 8'((i * 3 + 7) & 255);
      iram[i]    = 8'((i * 3 + 7) & 255);
    end
  endtask

  int s_cyc;

  task automatic do_start();
    @(negedge clk);
    start  = 1'b1;
    tb_clr = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    tb_clr = 1'b0;
    s_cyc  = cyc;
  endtask

  task automatic wait_finish(input string tag, input int max);
    int n;
    n = 0;
    while (!finish && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, finish, 1);
  endtask

  initial begin
    int   n;
    int   vc;
    logic [3:0] cmd0;

    reset      = 1'b1;
    start      = 1'b0;
    tb_clr     = 1'b0;
    force_busy = 1'b0;
    done_en    = 1'b1;
    load_list(45);
    load_img();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_rom_rd", bus.cmd_rom_rd, 0);
    chk("rst_rb_rd", bus.rb_rd, 0);
    chk("rst_cmds_sent", cmds_sent, 0);
    chk("rst_finish", finish, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {pass, timeout, err_cnt, bus.cmd, bus.cmd_rom_a}, 0);
    $display("test 0: reset state checked");

    // 1: full 46-command list ending in a write, clean image, stray start mid-run
    do_start();
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish("t1_finish", 1500);
    chk("t1_cmds_sent", cmds_sent, 46);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_pass", pass, 1);
    chk("t1_timeout", timeout, 0);
    chk("t1_accepts", acc_n, 46);
    chk("t1_cmd_order", seq_err, 0);
    chk("t1_rb_reads", rb_n, 64);
    chk("t1_rb_addr_seq", rb_seq_err, 0);
    $display("test 1: cmds_sent=%0d err_cnt=%0d pass=%0d", cmds_sent, err_cnt, pass);

    // 2 + 3: busy held during first ISSUE; write at entry 10 of 46
    load_list(10);
    force_busy = 1'b1;
    do_start();
    n = 0;
    while (!bus.cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t2_valid_seen", bus.cmd_valid, 1);
    cmd0 = bus.cmd;
    vc   = 1;
    repeat (5) begin
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd == cmd0) vc++;
    end
    chk("t2_no_early_accept", acc_n, 0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("t2_valid_cycles", vc, 6);
    chk("t2_hold_valid_low", bus.cmd_valid, 0);
    chk("t2_cmds_sent", cmds_sent, 1);
    chk("t2_accepts", acc_n, 1);
    chk("t2_cmd", cmd0, 1);
    $display("test 2: cmd_valid held %0d cycles under busy", vc);
    wait_finish("t3_finish", 1500);
    chk("t3_cmds_sent", cmds_sent, 11);
    chk("t3_accepts", acc_n, 11);
    chk("t3_no_valid_after_write", stray, 0);
    chk("t3_cmd_order", seq_err, 0);
    chk("t3_rb_after_done", rb_first, done_cyc + 1);
    chk("t3_pass", pass, 1);
    $display("test 3: cmds_sent=%0d readback at cycle %0d, done at %0d", cmds_sent, rb_first, done_cyc);

    // 4: three corrupted IRAM bytes
    load_list(45);
    iram[0]  = iram[0]  ^ 8'h5a;
    iram[31] = iram[31] ^ 8'h5a;
    iram[63] = iram[63] ^ 8'h5a;
    do_start();
    wait_finish("t4_finish", 1500);
    chk("t4_err_cnt", err_cnt, 3);
    chk("t4_pass", pass, 0);
    chk("t4_timeout", timeout, 0);
    chk("t4_cmds_sent", cmds_sent, 46);
    $display("test 4: err_cnt=%0d pass=%0d", err_cnt, pass);
    load_img();

    // 5: done never arrives
    done_en = 1'b0;
    do_start();
    wait_finish("t5_finish", 1200);
    chk("t5_timeout_cycle", cyc - s_cyc, 1000);
    chk("t5_timeout", timeout, 1);
    chk("t5_pass", pass, 0);
    chk("t5_cmd_valid", bus.cmd_valid, 0);
    chk("t5_rb_rd", bus.rb_rd, 0);
    chk("t5_cmds_sent", cmds_sent, 46);
    $display("test 5: timeout=%0d after %0d cycles", timeout, cyc - s_cyc);
    done_en = 1'b1;

    // 6: reset pulse during ISSUE, then a clean restart
    do_start();
    n = 0;
    while (!(bus.cmd_valid && cmds_sent == 7'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_issue", bus.cmd_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_cmd_valid", bus.cmd_valid, 0);
    chk("t6_rst_cmd", bus.cmd, 0);
    chk("t6_rst_cmds_sent", cmds_sent, 0);
    chk("t6_rst_cmd_rom_a", bus.cmd_rom_a, 0);
    @(negedge clk);
    reset = 1'b0;
    do_start();
    chk("t6_restart_rd", bus.cmd_rom_rd, 1);
    chk("t6_restart_addr", bus.cmd_rom_a, 0);
    wait_finish("t6_finish", 1500);
    chk("t6_cmds_sent", cmds_sent, 46);
    chk("t6_pass", pass, 1);
    $display("test 6: restart cmds_sent=%0d pass=%0d", cmds_sent, pass);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
